// File: rtl/pu_memarb_pkg.sv
// Shared op codes, arbiter state encoding and width helper for pu_memarb.
package pu_memarb_pkg;
  localparam logic [1:0] MEMNOOP        = 2'b00;
  localparam logic [1:0] MEMWRITEOP     = 2'b01;
  localparam logic [1:0] MEMREADOP      = 2'b10;
  localparam logic [1:0] MEMREADWRITEOP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width that never collapses to zero bits for a single channel.
  function automatic int idxw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pu_memarb_rrpick.sv
// Combinational picker: rotating search from ptr (mode=0) or lowest index first (mode=1).
module pu_memarb_rrpick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          mode,
  output logic          valid,
  output logic [IW-1:0] idx
);
  always_comb begin
    int c;
    c     = 0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      c = mode ? k : int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = IW'(c);
      end
    end
  end
endmodule

// File: rtl/pu_memarb.sv
// Arbitrates CHANNELCNT memory requesters onto one pi1 master port, with an
// optional watchdog that force-completes a stalled transaction with an error.
module pu_memarb
  import pu_memarb_pkg::*;
#(
  parameter int ARCHBITSZ     = 32,
  parameter int CHANNELCNT    = 3,
  parameter int PRIOMODE      = 0,
  parameter int TIMEOUTCYCLES = 0,
  localparam int ADDRBITSZ    = ARCHBITSZ - $clog2(ARCHBITSZ/8),
  localparam int SELW         = ARCHBITSZ/8,
  localparam int GW           = idxw(CHANNELCNT)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [2*CHANNELCNT-1:0]        m_op_i,
  input  logic [ADDRBITSZ*CHANNELCNT-1:0] m_addr_i,
  input  logic [ARCHBITSZ*CHANNELCNT-1:0] m_data_i,
  input  logic [SELW*CHANNELCNT-1:0]     m_sel_i,
  output logic [CHANNELCNT-1:0]          m_rdy_o,
  output logic [ARCHBITSZ-1:0]           m_data_o,
  output logic                           m_err_o,
  output logic [1:0]                     pi1_op_o,
  output logic [ADDRBITSZ-1:0]           pi1_addr_o,
  output logic [ARCHBITSZ-1:0]           pi1_data_o,
  output logic [SELW-1:0]                pi1_sel_o,
  input  logic [ARCHBITSZ-1:0]           pi1_data_i,
  input  logic                           pi1_rdy_i,
  output logic [GW-1:0]                  gnt_o
);
  state_t                state, state_nxt;
  logic [CHANNELCNT-1:0] req;
  logic                  pick_vld;
  logic [GW-1:0]         pick_idx, rr_ptr;
  logic                  tmo;
  logic [1:0]            win_op;
  logic [ADDRBITSZ-1:0]  win_addr;
  logic [ARCHBITSZ-1:0]  win_data;
  logic [SELW-1:0]       win_sel;
  logic [CHANNELCNT-1:0] gnt_oh;

  always_comb begin
    for (int i = 0; i < CHANNELCNT; i++) req[i] = (m_op_i[2*i +: 2] != MEMNOOP);
  end

  pu_memarb_rrpick #(.N(CHANNELCNT), .IW(GW)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .mode  (PRIOMODE != 0),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    int w;
    w        = int'(pick_idx);
    win_op   = m_op_i[2*w +: 2];
    win_addr = m_addr_i[ADDRBITSZ*w +: ADDRBITSZ];
    win_data = m_data_i[ARCHBITSZ*w +: ARCHBITSZ];
    win_sel  = m_sel_i[SELW*w +: SELW];
  end

  assign gnt_oh = CHANNELCNT'(1) << gnt_o;

  generate
    if (TIMEOUTCYCLES != 0) begin : g_wd
      localparam int WDW = $clog2(TIMEOUTCYCLES+1);
      logic [WDW-1:0] wd;
      always_ff @(posedge clk_i) begin
        if (rst_i)                                        wd <= '0;
        else if (state == BUSY && wd != WDW'(TIMEOUTCYCLES)) wd <= wd + 1'b1;
        else if (state == DONE)                           wd <= '0;
      end
      assign tmo = (state == BUSY) && (wd == WDW'(TIMEOUTCYCLES-1));
    end else begin : g_nowd
      assign tmo = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = BUSY;
      BUSY:    if (pi1_rdy_i || tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pi1_op_o   <= MEMNOOP;
      pi1_addr_o <= '0;
      pi1_data_o <= '0;
      pi1_sel_o  <= '0;
      m_rdy_o    <= '0;
      m_data_o   <= '0;
      m_err_o    <= 1'b0;
      gnt_o      <= '0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          pi1_op_o   <= win_op;
          pi1_addr_o <= win_addr;
          pi1_data_o <= win_data;
          pi1_sel_o  <= win_sel;
          gnt_o      <= pick_idx;
          if (PRIOMODE == 0)
            rr_ptr <= (pick_idx == GW'(CHANNELCNT-1)) ? '0 : pick_idx + 1'b1;
        end
        // Slave ready takes precedence over a coincident watchdog expiry.
        BUSY: if (pi1_rdy_i) begin
          pi1_op_o <= MEMNOOP;
          if (pi1_op_o[1]) m_data_o <= pi1_data_i;
          m_rdy_o  <= gnt_oh;
        end else if (tmo) begin
          pi1_op_o <= MEMNOOP;
          m_data_o <= '0;
          m_err_o  <= 1'b1;
          m_rdy_o  <= gnt_oh;
        end
        default: begin
          m_rdy_o <= '0;
          m_err_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pu_memarb.sv
// Scoreboard bench: stimulus queues expected pi1 issues and completions, monitors pop and compare.
module tb_pu_memarb;
  import pu_memarb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  m_op;
  logic [89:0] m_addr;
  logic [95:0] m_wdata;
  logic [11:0] m_sel;
  logic [31:0] rd_data = '0;
  logic        prdy = 1'b0;

  logic [2:0]  rdy0, rdy1;
  logic [31:0] mdata0, mdata1, pdata0, pdata1;
  logic        err0, err1;
  logic [1:0]  pop0, pop1, gnt0, gnt1;
  logic [29:0] paddr0, paddr1;
  logic [3:0]  psel0, psel1;

  pu_memarb #(.ARCHBITSZ(32), .CHANNELCNT(3), .PRIOMODE(0), .TIMEOUTCYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst), .m_op_i(m_op), .m_addr_i(m_addr), .m_data_i(m_wdata),
    .m_sel_i(m_sel), .m_rdy_o(rdy0), .m_data_o(mdata0), .m_err_o(err0), .pi1_op_o(pop0),
    .pi1_addr_o(paddr0), .pi1_data_o(pdata0), .pi1_sel_o(psel0), .pi1_data_i(rd_data),
    .pi1_rdy_i(prdy), .gnt_o(gnt0));

  pu_memarb #(.ARCHBITSZ(32), .CHANNELCNT(3), .PRIOMODE(1), .TIMEOUTCYCLES(0)) dut_prio (
    .clk_i(clk), .rst_i(rst), .m_op_i(m_op), .m_addr_i(m_addr), .m_data_i(m_wdata),
    .m_sel_i(m_sel), .m_rdy_o(rdy1), .m_data_o(mdata1), .m_err_o(err1), .pi1_op_o(pop1),
    .pi1_addr_o(paddr1), .pi1_data_o(pdata1), .pi1_sel_o(psel1), .pi1_data_i(rd_data),
    .pi1_rdy_i(1'b1), .gnt_o(gnt1));

  always #5 clk = ~clk;

  typedef struct {int ch; logic [31:0] data; logic err; int blen;} cmp_t;
  typedef struct {logic [1:0] op; logic [29:0] addr; logic [31:0] data; logic [3:0] sel; int gap;} iss_t;

  cmp_t cmpq[$];
  iss_t issq[$];
  int   ntests = 0, nfail = 0;
  int   cyc = 0, last_iss = 0, blen = 0, bcnt = 0, lat = 0, prio_n = 0;
  logic [1:0]  prev_op = MEMNOOP;
  logic [67:0] cap;

  logic [1:0]  cur_op[3], sav_op[3];
  logic [29:0] cur_addr[3];
  logic [31:0] cur_wd[3];
  logic [3:0]  cur_sel[3];
  int          nrem[3];
  bit          reasrt[3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      m_op[2*i +: 2]     = cur_op[i];
      m_addr[30*i +: 30] = cur_addr[i];
      m_wdata[32*i +: 32] = cur_wd[i];
      m_sel[4*i +: 4]    = cur_sel[i];
    end
  end

  function automatic void chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  always @(posedge clk) cyc++;

  // pi1 slave: raises rdy on the lat-th BUSY cycle (lat < 0 means never).
  always @(negedge clk) begin
    if (pop0 != MEMNOOP) begin
      prdy = (lat >= 0 && bcnt == lat);
      bcnt++;
    end else begin
      prdy = 1'b0;
      bcnt = 0;
    end
  end

  // Requesters drop op on their completion pulse and optionally re-assert one cycle later.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reasrt[i]) begin
        cur_op[i] = sav_op[i];
        reasrt[i] = 1'b0;
      end else if (rdy0[i] === 1'b1 && cur_op[i] != MEMNOOP) begin
        cur_op[i] = MEMNOOP;
        if (nrem[i] > 1) begin
          nrem[i]--;
          reasrt[i] = 1'b1;
        end else nrem[i] = 0;
      end
    end
  end

  // Issue monitor: checks each new pi1 transaction and its stability while BUSY.
  always @(negedge clk) begin
    iss_t e;
    if (pop0 != MEMNOOP) begin
      if (prev_op == MEMNOOP) begin
        if (issq.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL unexpected issue: op %0h addr %0h", pop0, paddr0);
        end else begin
          e = issq.pop_front();
          chk("issue op", pop0, e.op);
          chk("issue addr", paddr0, e.addr);
          chk("issue data", pdata0, e.data);
          chk("issue sel", psel0, e.sel);
          if (e.gap >= 0) chk("issue gap", cyc - last_iss, e.gap);
        end
        cap = {pop0, paddr0, pdata0, psel0};
        blen = 1;
        last_iss = cyc;
      end else begin
        chk("pi1 stable", {pop0, paddr0, pdata0, psel0}, cap);
        blen++;
      end
    end
    prev_op = pop0;
  end

  // Completion monitor.
  always @(negedge clk) begin
    cmp_t c;
    if (rdy0 != 3'b000) begin
      if (cmpq.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL unexpected completion: m_rdy %0b", rdy0);
      end else begin
        c = cmpq.pop_front();
        chk("rdy onehot", rdy0, 3'b001 << c.ch);
        chk("gnt", gnt0, c.ch);
        chk("rd data", mdata0, c.data);
        chk("err", err0, c.err);
        chk("pi1 op idle", pop0, MEMNOOP);
        chk("busy len", blen, c.blen);
      end
    end
  end

  always @(negedge clk) begin
    if (rdy1 != 3'b000 && prio_n > 0) begin
      chk("prio grant", rdy1, 3'b001);
      prio_n--;
    end
  end

  task automatic push_iss(input logic [1:0] op, input logic [29:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int gap);
    iss_t e;
    e.op = op; e.addr = a; e.data = d; e.sel = s; e.gap = gap;
    issq.push_back(e);
  endtask

  task automatic push_cmp(input int ch, input logic [31:0] d, input logic err, input int bl);
    cmp_t c;
    c.ch = ch; c.data = d; c.err = err; c.blen = bl;
    cmpq.push_back(c);
  endtask

  task automatic go(input int ch, input logic [1:0] op, input logic [29:0] a,
                    input logic [31:0] d, input logic [3:0] s, input int n);
    cur_addr[ch] = a; cur_wd[ch] = d; cur_sel[ch] = s;
    sav_op[ch] = op; nrem[ch] = n; cur_op[ch] = op;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((cmpq.size() != 0 || issq.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (cmpq.size() != 0 || issq.size() != 0) begin
      ntests++; nfail++;
      $display("FAIL wait timeout: %0d completions and %0d issues pending", cmpq.size(), issq.size());
      cmpq.delete();
      issq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      cur_op[i] = MEMNOOP; sav_op[i] = MEMNOOP; cur_addr[i] = '0;
      cur_wd[i] = '0; cur_sel[i] = '0; nrem[i] = 0; reasrt[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("reset pi1", {pop0, paddr0, pdata0, psel0}, '0);
    chk("reset m_rdy", rdy0, 3'b000);
    chk("reset m_data", mdata0, 32'h0);
    chk("reset err/gnt", {err0, gnt0}, 3'b000);
    rst = 1'b0;
    @(negedge clk);

    // Single read on ch1, slave ready after 2 cycles.
    lat = 2; rd_data = 32'hDEADBEEF;
    push_iss(MEMREADOP, 30'h100, 32'h0, 4'hF, -1);
    push_cmp(1, 32'hDEADBEEF, 1'b0, 3);
    go(1, MEMREADOP, 30'h100, 32'h0, 4'hF, 1);
    wait_idle(50);

    // Write on ch2: read data register must keep its previous value.
    lat = 1; rd_data = 32'hBAD0BAD0;
    push_iss(MEMWRITEOP, 30'h3FF, 32'h12345678, 4'b0011, -1);
    push_cmp(2, 32'hDEADBEEF, 1'b0, 2);
    go(2, MEMWRITEOP, 30'h3FF, 32'h12345678, 4'b0011, 1);
    wait_idle(50);

    // Watchdog expiry after 8 BUSY cycles.
    lat = -1; rd_data = 32'h55555555;
    push_iss(MEMREADOP, 30'h20, 32'h0, 4'hF, -1);
    push_cmp(0, 32'h0, 1'b1, 8);
    go(0, MEMREADOP, 30'h20, 32'h0, 4'hF, 1);
    wait_idle(50);

    // Slave ready coincides with watchdog expiry: ready wins.
    lat = 7; rd_data = 32'hCAFEF00D;
    push_iss(MEMREADOP, 30'h21, 32'h0, 4'hF, -1);
    push_cmp(1, 32'hCAFEF00D, 1'b0, 8);
    go(1, MEMREADOP, 30'h21, 32'h0, 4'hF, 1);
    wait_idle(50);

    // Reset while BUSY on ch0 (rr pointer moved to 1 first).
    lat = -1;
    push_iss(MEMREADWRITEOP, 30'h40, 32'hA5A5A5A5, 4'hF, -1);
    go(0, MEMREADWRITEOP, 30'h40, 32'hA5A5A5A5, 4'hF, 1);
    begin
      int k;
      k = 0;
      while (pop0 == MEMNOOP && k < 20) begin @(negedge clk); k++; end
      chk("abort issued", pop0, MEMREADWRITEOP);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1; cur_op[0] = MEMNOOP; nrem[0] = 0;
    @(negedge clk);
    chk("abort op", pop0, MEMNOOP);
    chk("abort rdy", rdy0, 3'b000);
    chk("abort gnt", gnt0, 2'd0);
    rst = 1'b0;
    @(negedge clk);

    // Round-robin with all three held: 0,1,2,0; priority instance gives 0,0,0.
    lat = 0; rd_data = 32'h0F0F0F0F; prio_n = 3;
    push_iss(MEMREADOP, 30'h10, 32'h0, 4'hF, -1);
    push_iss(MEMREADOP, 30'h11, 32'h0, 4'hF, 3);
    push_iss(MEMREADOP, 30'h12, 32'h0, 4'hF, 3);
    push_iss(MEMREADOP, 30'h10, 32'h0, 4'hF, 3);
    push_cmp(0, 32'h0F0F0F0F, 1'b0, 1);
    push_cmp(1, 32'h0F0F0F0F, 1'b0, 1);
    push_cmp(2, 32'h0F0F0F0F, 1'b0, 1);
    push_cmp(0, 32'h0F0F0F0F, 1'b0, 1);
    go(0, MEMREADOP, 30'h10, 32'h0, 4'hF, 2);
    go(1, MEMREADOP, 30'h11, 32'h0, 4'hF, 1);
    go(2, MEMREADOP, 30'h12, 32'h0, 4'hF, 1);
    wait_idle(100);

    // Plain ch2 request after the reset.
    lat = 0;
    push_iss(MEMWRITEOP, 30'h7, 32'h1, 4'h1, -1);
    push_cmp(2, 32'h0F0F0F0F, 1'b0, 1);
    go(2, MEMWRITEOP, 30'h7, 32'h1, 4'h1, 1);
    wait_idle(50);

    // Back-to-back on ch0: one issue every 3 cycles.
    lat = 0; rd_data = 32'h600D600D;
    push_iss(MEMREADOP, 30'h30, 32'h0, 4'hF, -1);
    push_iss(MEMREADOP, 30'h30, 32'h0, 4'hF, 3);
    push_iss(MEMREADOP, 30'h30, 32'h0, 4'hF, 3);
    for (int i = 0; i < 3; i++) push_cmp(0, 32'h600D600D, 1'b0, 1);
    go(0, MEMREADOP, 30'h30, 32'h0, 4'hF, 3);
    wait_idle(100);

    chk("prio checks done", prio_n, 0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
